// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and
// forwarding-mux select values.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } haz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MM = 2'b10;
    localparam logic [1:0] FWD_WB = 2'b01;

    // Remaining branch-flush cycles; BR_PENALTY tops out at 4, so at most 3 remain.
    localparam int FLUSH_W = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The master modport is the pipeline
// side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] ifid_rs, ifid_rt;
    logic [REG_AW-1:0] idex_rs, idex_rt;
    logic              idex_memread;
    logic [REG_AW-1:0] exmm_rd, exmm_rt;
    logic              exmm_regwrite, exmm_memread, exmm_memwrite;
    logic [REG_AW-1:0] mmwb_rd;
    logic              mmwb_regwrite;
    logic              br_taken, jump;
    logic              mem_ready;

    logic              pc_write, ifid_write, idex_write, exmm_write;
    logic              ifid_clear, idex_clear, mmwb_clear;
    logic [1:0]        forward_a, forward_b;
    logic              forward_m;
    logic              mem_timeout;

    modport master (
        output ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
               exmm_rd, exmm_rt, exmm_regwrite, exmm_memread, exmm_memwrite,
               mmwb_rd, mmwb_regwrite, br_taken, jump, mem_ready,
        input  pc_write, ifid_write, idex_write, exmm_write,
               ifid_clear, idex_clear, mmwb_clear,
               forward_a, forward_b, forward_m, mem_timeout
    );

    modport slave (
        input  ifid_rs, ifid_rt, idex_rs, idex_rt, idex_memread,
               exmm_rd, exmm_rt, exmm_regwrite, exmm_memread, exmm_memwrite,
               mmwb_rd, mmwb_regwrite, br_taken, jump, mem_ready,
        output pc_write, ifid_write, idex_write, exmm_write,
               ifid_clear, idex_clear, mmwb_clear,
               forward_a, forward_b, forward_m, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding source select for one consumer register: the EX/MM producer wins
// over MM/WB, and register 0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              exmm_regwrite,
    input  logic [REG_AW-1:0] exmm_rd,
    input  logic              mmwb_regwrite,
    input  logic [REG_AW-1:0] mmwb_rd,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (exmm_regwrite && (exmm_rd != '0) && (exmm_rd == src)) begin
            sel = FWD_MM;
        end else if (mmwb_regwrite && (mmwb_rd != '0) && (mmwb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stall,
// branch flush and memory-wait freeze. Perf counters under HAZ_PERF_CNT_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; branch/jump clears IF/ID, may enter BR_FLUSH
// MEM_WAIT | data memory busy; freeze until mem_ready, watchdog counting
// BR_FLUSH | multi-cycle branch penalty; IF/ID held as bubble
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 16
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt_total,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int                WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'(MEM_TIMEOUT - 1);

    haz_state_e         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_nxt;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               mem_timeout_q;

    logic memop, freeze, load_use, in_flush, stall, br_start;
    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_m_sel;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src(hz.idex_rs), .exmm_regwrite(hz.exmm_regwrite), .exmm_rd(hz.exmm_rd),
        .mmwb_regwrite(hz.mmwb_regwrite), .mmwb_rd(hz.mmwb_rd), .sel(fwd_a_sel)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src(hz.idex_rt), .exmm_regwrite(hz.exmm_regwrite), .exmm_rd(hz.exmm_rd),
        .mmwb_regwrite(hz.mmwb_regwrite), .mmwb_rd(hz.mmwb_rd), .sel(fwd_b_sel)
    );

    // Store data only ever comes from WB, so the EX/MM leg is disabled here.
    fwd_select #(.REG_AW(REG_AW)) u_fwd_m (
        .src(hz.exmm_rt), .exmm_regwrite(1'b0), .exmm_rd('0),
        .mmwb_regwrite(hz.mmwb_regwrite), .mmwb_rd(hz.mmwb_rd), .sel(fwd_m_sel)
    );

    always_comb begin
        memop    = hz.exmm_memread | hz.exmm_memwrite;
        freeze   = memop & ~hz.mem_ready;
        load_use = hz.idex_memread && (hz.idex_rt != '0) &&
                   ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));
        // The release cycle of MEM_WAIT behaves like whichever state it returns to.
        in_flush = (state == BR_FLUSH) || ((state == MEM_WAIT) && (flush_cnt != '0));
        stall    = !freeze && load_use;
        br_start = !freeze && !load_use && !in_flush && (hz.br_taken || hz.jump);
        if (state != MEM_WAIT) begin
            wait_nxt = WAIT_W'(1);
        end else if (wait_cnt == TO_LIM) begin
            wait_nxt = wait_cnt;
        end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_write  = 1'b1;
        hz.exmm_write  = 1'b1;
        hz.ifid_clear  = 1'b0;
        hz.idex_clear  = 1'b0;
        hz.mmwb_clear  = 1'b0;
        hz.forward_a   = FWD_RF;
        hz.forward_b   = FWD_RF;
        hz.forward_m   = 1'b0;
        hz.mem_timeout = 1'b0;
        if (rst) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.idex_write = 1'b0;
            hz.exmm_write = 1'b0;
            hz.ifid_clear = 1'b1;
            hz.idex_clear = 1'b1;
            hz.mmwb_clear = 1'b1;
        end else begin
            hz.forward_a   = fwd_a_sel;
            hz.forward_b   = fwd_b_sel;
            hz.forward_m   = hz.exmm_memwrite && (fwd_m_sel == FWD_WB);
            hz.mem_timeout = mem_timeout_q;
            hz.ifid_clear  = in_flush || br_start;
            if (freeze) begin
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
                hz.idex_write = 1'b0;
                hz.exmm_write = 1'b0;
                hz.mmwb_clear = 1'b1;
            end else if (stall) begin
                hz.pc_write   = 1'b0;
                hz.ifid_write = 1'b0;
                hz.idex_clear = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            wait_cnt      <= '0;
            flush_cnt     <= '0;
            mem_timeout_q <= 1'b0;
        end else if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= wait_nxt;
            if (wait_nxt == TO_LIM) begin
                mem_timeout_q <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
            if (in_flush) begin
                flush_cnt <= flush_cnt - FLUSH_W'(1);
                state     <= (flush_cnt == FLUSH_W'(1)) ? RUN : BR_FLUSH;
            end else if (br_start && (BR_PENALTY > 1)) begin
                flush_cnt <= FLUSH_W'(BR_PENALTY - 1);
                state     <= BR_FLUSH;
            end else begin
                state <= RUN;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt       <= '0;
            flush_cnt_total <= '0;
            memwait_cnt     <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((in_flush || br_start) && (flush_cnt_total != '1)) begin
                flush_cnt_total <= flush_cnt_total + CNT_W'(1);
            end
            if (freeze && (memwait_cnt != '1)) begin
                memwait_cnt <= memwait_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (BR_PENALTY=3, MEM_TIMEOUT=16).
// Inputs change 1ns after posedge; outputs are sampled 3ns later.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int REG_AW      = 5;
    localparam int BR_PENALTY  = 3;
    localparam int MEM_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt_total, memwait_cnt;
`endif

    pipeline_hazard_ctrl #(
        .REG_AW(REG_AW), .BR_PENALTY(BR_PENALTY), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt_total(flush_cnt_total),
        .memwait_cnt(memwait_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] writes();
        return {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmm_write};
    endfunction

    function automatic logic [2:0] clears();
        return {hz.ifid_clear, hz.idex_clear, hz.mmwb_clear};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.ifid_rs = '0; hz.ifid_rt = '0; hz.idex_rs = '0; hz.idex_rt = '0;
        hz.idex_memread = 1'b0;
        hz.exmm_rd = '0; hz.exmm_rt = '0;
        hz.exmm_regwrite = 1'b0; hz.exmm_memread = 1'b0; hz.exmm_memwrite = 1'b0;
        hz.mmwb_rd = '0; hz.mmwb_regwrite = 1'b0;
        hz.br_taken = 1'b0; hz.jump = 1'b0; hz.mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        hz.exmm_regwrite = 1'b1; hz.exmm_rd = 5'd4; hz.idex_rs = 5'd4;
        tick(); tick();
        #3;
        n_checks++;
        if (writes() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_writes: got %b want %b", writes(), 4'b0000);
        end
        n_checks++;
        if (clears() !== 3'b111) begin
            n_fail++; $display("FAIL reset_clears: got %b want %b", clears(), 3'b111);
        end
        n_checks++;
        if (hz.forward_a !== FWD_RF || hz.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_fwd_to: got fa=%b to=%b want fa=00 to=0",
                               hz.forward_a, hz.mem_timeout);
        end
        tick();
        rst = 1'b0;
        idle();
        #3;
        n_checks++;
        if (writes() !== 4'b1111 || clears() !== 3'b000) begin
            n_fail++; $display("FAIL after_reset_default: got w=%b c=%b want w=1111 c=000",
                               writes(), clears());
        end
    endtask

    task automatic test_forwarding();
        tick();
        idle();
        hz.exmm_rd = 5'd5; hz.mmwb_rd = 5'd5; hz.idex_rs = 5'd5; hz.idex_rt = 5'd5;
        hz.exmm_regwrite = 1'b1; hz.mmwb_regwrite = 1'b1;
        #3;
        n_checks++;
        if (hz.forward_a !== 2'b10 || hz.forward_b !== 2'b10) begin
            n_fail++; $display("FAIL fwd_mm_priority: got a=%b b=%b want a=10 b=10",
                               hz.forward_a, hz.forward_b);
        end
        hz.exmm_regwrite = 1'b0;
        #1;
        n_checks++;
        if (hz.forward_a !== 2'b01 || hz.forward_b !== 2'b01) begin
            n_fail++; $display("FAIL fwd_wb: got a=%b b=%b want a=01 b=01",
                               hz.forward_a, hz.forward_b);
        end
        hz.exmm_regwrite = 1'b1;
        hz.exmm_rd = '0; hz.mmwb_rd = '0; hz.idex_rs = '0; hz.idex_rt = '0;
        #1;
        n_checks++;
        if (hz.forward_a !== 2'b00 || hz.forward_b !== 2'b00) begin
            n_fail++; $display("FAIL fwd_r0: got a=%b b=%b want a=00 b=00",
                               hz.forward_a, hz.forward_b);
        end
        hz.idex_rs = 5'd5; hz.idex_rt = 5'd7; hz.exmm_rd = 5'd5; hz.mmwb_rd = 5'd7;
        #1;
        n_checks++;
        if (hz.forward_a !== 2'b10 || hz.forward_b !== 2'b01) begin
            n_fail++; $display("FAIL fwd_split: got a=%b b=%b want a=10 b=01",
                               hz.forward_a, hz.forward_b);
        end
        idle();
        hz.exmm_memwrite = 1'b1; hz.exmm_rt = 5'd9; hz.mmwb_rd = 5'd9; hz.mmwb_regwrite = 1'b1;
        #1;
        n_checks++;
        if (hz.forward_m !== 1'b1) begin
            n_fail++; $display("FAIL fwd_m_hit: got %b want 1", hz.forward_m);
        end
        hz.exmm_rt = '0; hz.mmwb_rd = '0;
        #1;
        n_checks++;
        if (hz.forward_m !== 1'b0) begin
            n_fail++; $display("FAIL fwd_m_r0: got %b want 0", hz.forward_m);
        end
        hz.exmm_rt = 5'd9; hz.mmwb_rd = 5'd9; hz.exmm_memwrite = 1'b0;
        #1;
        n_checks++;
        if (hz.forward_m !== 1'b0) begin
            n_fail++; $display("FAIL fwd_m_nostore: got %b want 0", hz.forward_m);
        end
    endtask

    task automatic test_load_use();
        tick();
        idle();
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd3; hz.ifid_rt = 5'd3;
        #3;
        n_checks++;
        if (writes() !== 4'b0011 || clears() !== 3'b010) begin
            n_fail++; $display("FAIL load_use_rt: got w=%b c=%b want w=0011 c=010",
                               writes(), clears());
        end
        tick();
        hz.idex_memread = 1'b0;
        #3;
        n_checks++;
        if (writes() !== 4'b1111 || clears() !== 3'b000) begin
            n_fail++; $display("FAIL load_use_one_bubble: got w=%b c=%b want w=1111 c=000",
                               writes(), clears());
        end
        tick();
        idle();
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd6; hz.ifid_rs = 5'd6;
        #3;
        n_checks++;
        if (writes() !== 4'b0011 || clears() !== 3'b010) begin
            n_fail++; $display("FAIL load_use_rs: got w=%b c=%b want w=0011 c=010",
                               writes(), clears());
        end
        tick();
        idle();
        hz.idex_memread = 1'b1;
        #3;
        n_checks++;
        if (writes() !== 4'b1111 || clears() !== 3'b000) begin
            n_fail++; $display("FAIL load_use_r0: got w=%b c=%b want w=1111 c=000",
                               writes(), clears());
        end
    endtask

    task automatic test_mem_wait();
        for (int k = 1; k <= 4; k++) begin
            tick();
            idle();
            hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
            #3;
            n_checks++;
            if (writes() !== 4'b0000 || hz.mmwb_clear !== 1'b1) begin
                n_fail++; $display("FAIL mem_wait_freeze[%0d]: got w=%b mmwb_clear=%b want w=0000 mmwb_clear=1",
                                   k, writes(), hz.mmwb_clear);
            end
        end
        tick();
        hz.mem_ready = 1'b1;
        #3;
        n_checks++;
        if (writes() !== 4'b1111 || hz.mmwb_clear !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_release: got w=%b mmwb_clear=%b want w=1111 mmwb_clear=0",
                               writes(), hz.mmwb_clear);
        end
        tick();
        idle();
        #3;
        n_checks++;
        if (hz.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mem_wait_no_timeout: got %b want 0", hz.mem_timeout);
        end
    endtask

    task automatic test_watchdog();
        logic exp_to;
        for (int k = 1; k <= 20; k++) begin
            tick();
            idle();
            hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
            #3;
            // Flag is registered at the end of the 15th frozen cycle.
            exp_to = (k >= MEM_TIMEOUT);
            n_checks++;
            if (hz.mem_timeout !== exp_to) begin
                n_fail++; $display("FAIL watchdog[%0d]: got %b want %b", k, hz.mem_timeout, exp_to);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            idle();
            #3;
            n_checks++;
            if (hz.mem_timeout !== 1'b1 || writes() !== 4'b1111) begin
                n_fail++; $display("FAIL watchdog_sticky[%0d]: got to=%b w=%b want to=1 w=1111",
                                   k, hz.mem_timeout, writes());
            end
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        n_checks++;
        if (hz.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL watchdog_rst_clear: got %b want 0", hz.mem_timeout);
        end
    endtask

    task automatic test_branch();
        logic exp_c;
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            hz.br_taken = (k == 1);
            #3;
            exp_c = (k <= BR_PENALTY);
            n_checks++;
            if (hz.ifid_clear !== exp_c || writes() !== 4'b1111) begin
                n_fail++; $display("FAIL branch_flush[%0d]: got clr=%b w=%b want clr=%b w=1111",
                                   k, hz.ifid_clear, writes(), exp_c);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            hz.jump = (k == 1);
            #3;
            exp_c = (k <= BR_PENALTY);
            n_checks++;
            if (hz.ifid_clear !== exp_c) begin
                n_fail++; $display("FAIL jump_flush[%0d]: got %b want %b", k, hz.ifid_clear, exp_c);
            end
        end
    endtask

    task automatic test_branch_freeze();
        logic exp_c;
        logic [3:0] exp_w;
        for (int k = 1; k <= 6; k++) begin
            tick();
            idle();
            hz.br_taken = (k == 1);
            if (k == 2) begin
                hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
            end
            #3;
            exp_c = (k <= BR_PENALTY + 1);
            exp_w = (k == 2) ? 4'b0000 : 4'b1111;
            n_checks++;
            if (hz.ifid_clear !== exp_c || writes() !== exp_w) begin
                n_fail++; $display("FAIL branch_freeze[%0d]: got clr=%b w=%b want clr=%b w=%b",
                                   k, hz.ifid_clear, writes(), exp_c, exp_w);
            end
        end
    endtask

    task automatic test_simultaneous();
        tick();
        idle();
        hz.br_taken = 1'b1; hz.idex_memread = 1'b1; hz.idex_rt = 5'd3; hz.ifid_rs = 5'd3;
        #3;
        n_checks++;
        if (clears() !== 3'b010 || writes() !== 4'b0011) begin
            n_fail++; $display("FAIL br_with_load_use: got c=%b w=%b want c=010 w=0011",
                               clears(), writes());
        end
        tick();
        idle();
        #3;
        n_checks++;
        if (hz.ifid_clear !== 1'b0) begin
            n_fail++; $display("FAIL br_with_load_use_after: got %b want 0", hz.ifid_clear);
        end
        tick();
        idle();
        hz.br_taken = 1'b1; hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
        #3;
        n_checks++;
        if (clears() !== 3'b001 || writes() !== 4'b0000) begin
            n_fail++; $display("FAIL br_with_freeze: got c=%b w=%b want c=001 w=0000",
                               clears(), writes());
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            idle();
            #3;
            n_checks++;
            if (hz.ifid_clear !== 1'b0 || writes() !== 4'b1111) begin
                n_fail++; $display("FAIL br_with_freeze_after[%0d]: got clr=%b w=%b want clr=0 w=1111",
                                   k, hz.ifid_clear, writes());
            end
        end
        // Reset in BR_FLUSH must abandon the remaining penalty.
        tick();
        idle();
        hz.br_taken = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        n_checks++;
        if (hz.ifid_clear !== 1'b0 || writes() !== 4'b1111) begin
            n_fail++; $display("FAIL rst_in_br_flush: got clr=%b w=%b want clr=0 w=1111",
                               hz.ifid_clear, writes());
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            idle();
            hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
        end
        tick();
        rst = 1'b1;
        #3;
        n_checks++;
        if (writes() !== 4'b0000 || clears() !== 3'b111) begin
            n_fail++; $display("FAIL rst_in_mem_wait: got w=%b c=%b want w=0000 c=111",
                               writes(), clears());
        end
        tick();
        rst = 1'b0;
        idle();
        #3;
        n_checks++;
        if (writes() !== 4'b1111 || clears() !== 3'b000) begin
            n_fail++; $display("FAIL rst_in_mem_wait_after: got w=%b c=%b want w=1111 c=000",
                               writes(), clears());
        end
        // Wait count must restart from zero after the reset.
        for (int k = 1; k <= MEM_TIMEOUT - 1; k++) begin
            tick();
            idle();
            hz.exmm_memread = 1'b1; hz.mem_ready = 1'b0;
        end
        #3;
        n_checks++;
        if (hz.mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_cnt_restart: got %b want 0", hz.mem_timeout);
        end
        tick();
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_watchdog();
        test_branch();
        test_branch_freeze();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Unified, parametrised hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MM/WB).
- Merges operand forwarding, store-data forwarding, load-use stall and branch/jump flush into one block.
- Adds an FSM for variable-latency data memory (mem_ready handshake with watchdog) and a multi-cycle branch flush penalty.
- Sits beside the pipeline registers and drives their write-enable and clear controls plus the forwarding muxes.

Parameters:
REG_AW, 5, register-index width (register 0 is hardwired zero).
BR_PENALTY, 1, cycles of IF/ID flush after a taken branch or jump; legal 1..4.
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before mem_timeout; legal >= 2.
CNT_W, 32, performance counter width (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifid_rs, ifid_rt  in  REG_AW  source registers of the instruction in ID
idex_rs, idex_rt  in  REG_AW  source registers of the instruction in EX
idex_memread  in  1  EX instruction is a load
exmm_rd, exmm_rt  in  REG_AW  MM destination register and store-data register
exmm_regwrite, exmm_memread, exmm_memwrite  in  1  MM-stage controls
mmwb_rd  in  REG_AW  WB destination register
mmwb_regwrite  in  1  WB write enable
br_taken, jump  in  1  ID-stage branch taken / jump resolved
mem_ready  in  1  data memory completes the MM access this cycle
pc_write, ifid_write, idex_write, exmm_write  out  1  pipeline-register enables
ifid_clear, idex_clear, mmwb_clear  out  1  insert a bubble into that register
forward_a, forward_b  out  2  ALU operand select: 00 regfile, 10 EX/MM, 01 MM/WB
forward_m  out  1  store data taken from WB
mem_timeout  out  1  sticky watchdog flag

Behaviour:
Reset:
- While rst is high: all *_write=0, all *_clear=1, forward_*=0, mem_timeout=0, state=RUN, all counters=0.

Forwarding (combinational, independent of the FSM):
- forward_a=10 if exmm_regwrite && exmm_rd!=0 && exmm_rd==idex_rs; else 01 under the same test on mmwb_*; else 00.
- forward_b is identical but compares against idex_rt in both tests.
- forward_m = exmm_memwrite && mmwb_regwrite && mmwb_rd!=0 && mmwb_rd==exmm_rt.

Derived conditions:
- memop = exmm_memread | exmm_memwrite.
- load_use = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).

FSM states: RUN, MEM_WAIT, BR_FLUSH. Stall priority: memory freeze > load-use > branch/jump flush.

Memory freeze (any state):
- Triggered when memop && !mem_ready.
- pc/ifid/idex/exmm_write=0, mmwb_clear=1; br_taken and jump are ignored that cycle.
- In RUN: go to MEM_WAIT, wait_cnt=1.
- In MEM_WAIT: wait_cnt++. When wait_cnt reaches MEM_TIMEOUT-1, set mem_timeout (sticky until rst) and remain in MEM_WAIT.
- Leaving MEM_WAIT: the cycle mem_ready=1, the freeze drops that same cycle; return to RUN, or to BR_FLUSH if a flush is still outstanding (flush_cnt>0).

Load-use (RUN or BR_FLUSH, no freeze):
- pc_write=0, ifid_write=0, idex_clear=1; exactly one bubble; br_taken is ignored.

Branch/jump (RUN, no higher-priority stall, br_taken|jump):
- ifid_clear=1 this cycle.
- If BR_PENALTY>1: flush_cnt=BR_PENALTY-1 and go to BR_FLUSH.

BR_FLUSH:
- ifid_clear=1 each cycle; flush_cnt decrements each cycle not frozen; go to RUN when it reaches 0.
- A new br_taken|jump here is ignored (ID holds a bubble).

Default: all writes=1, all clears=0.

Reset mid-MEM_WAIT or mid-BR_FLUSH: abandon immediately; values as in Reset.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, flush_cnt_total, memwait_cnt (each CNT_W bits, saturating at all-ones, cleared by rst). They count cycles with load_use stall, ifid_clear due to branch/jump, and memory freeze respectively.
- When undefined, these ports and registers are absent and there is no other behavioural change.

Decomposition:
- Shared package hazard_pkg holds:
  - FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, BR_FLUSH=2'd2);
  - forwarding-select constants FWD_RF=2'b00, FWD_MM=2'b10, FWD_WB=2'b01.
- One natural sub-module: fwd_select, the combinational forwarding logic, instantiated once for A/B and reused for the M comparison.

Test Plan:
- Forward priority: exmm_rd=mmwb_rd=idex_rs=idex_rt=5, both regwrite=1 -> forward_a=forward_b=10; with exmm_regwrite=0 -> 01; with all rd=0 -> 00.
- Load-use: idex_memread=1, idex_rt=3, ifid_rt=3 -> one cycle of pc_write=0, ifid_write=0, idex_clear=1; with idex_rt=0 -> no stall.
- Memory wait: exmm_memread=1, mem_ready low for 4 cycles -> 4 frozen cycles with mmwb_clear=1; release the cycle mem_ready=1; mem_timeout stays 0.
- Watchdog: MEM_TIMEOUT=16, mem_ready held low 20 cycles -> mem_timeout rises on cycle 15 and stays high after mem_ready; clears only on rst.
- Branch penalty: BR_PENALTY=3, br_taken pulse -> ifid_clear high exactly 3 cycles; freeze injected in cycle 2 extends this to 4 cycles total.
- Simultaneous: br_taken with load_use -> stall only, no ifid_clear; br_taken with memory freeze -> freeze only; rst asserted during MEM_WAIT -> next cycle RUN with default enables.
